// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared width defaults, FSM state encodings and port ids
// for the two-port DRAM arbiter slice, plus a counter-width helper.
package dram_arbiter_pkg;

    localparam int unsigned DATA_W_DEF  = 24;
    localparam int unsigned ADDR_W_DEF  = 11;
    localparam int unsigned ACC_CYC_DEF = 2;
    localparam int unsigned STARVE_DEF  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: CPU port, aux (loader/debug) port and DRAM side of the
// arbiter. slave = arbiter view, master = requesters/DRAM model view.
interface dram_arbiter_if #(
    parameter int unsigned DATA_BUS_WIDTH    = dram_arbiter_pkg::DATA_W_DEF,
    parameter int unsigned ADDRESS_BUS_WIDTH = dram_arbiter_pkg::ADDR_W_DEF
) ();
    logic                         cpu_req;
    logic                         cpu_rnw;
    logic [ADDRESS_BUS_WIDTH-1:0] cpu_addr;
    logic [DATA_BUS_WIDTH-1:0]    cpu_wdata;
    logic                         cpu_ack;
    logic [DATA_BUS_WIDTH-1:0]    cpu_rdata;
    logic                         cpu_stall;

    logic                         aux_req;
    logic                         aux_rnw;
    logic [ADDRESS_BUS_WIDTH-1:0] aux_addr;
    logic [DATA_BUS_WIDTH-1:0]    aux_wdata;
    logic                         aux_ack;
    logic [DATA_BUS_WIDTH-1:0]    aux_rdata;

    logic                         mem_cs;
    logic                         mem_rnw;
    logic [ADDRESS_BUS_WIDTH-1:0] mem_addr;
    logic [DATA_BUS_WIDTH-1:0]    mem_wdata;
    logic [DATA_BUS_WIDTH-1:0]    mem_rdata;

    logic                         owner;
    logic                         busy;

    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  aux_req, aux_rnw, aux_addr, aux_wdata,
        output aux_ack, aux_rdata,
        output mem_cs, mem_rnw, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner, busy
    );

    modport master (
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output aux_req, aux_rnw, aux_addr, aux_wdata,
        input  aux_ack, aux_rdata,
        input  mem_cs, mem_rnw, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner, busy
    );

endinterface

// File: rtl/dram_arbiter_access_timer.sv
// dram_arbiter_access_timer: down-counter timing one DRAM access.
// Ports: clk, rst_n, load_i/load_val_i (preset), dec_i (count), last_o (==1).
module dram_arbiter_access_timer
    import dram_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: IDLE->BUSY->ACK arbiter sharing one DRAM between CPU and aux.
// Ports: clk, rst_n, bus (dram_arbiter_if.slave). Option: ARB_STARVE_GUARD_EN.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH    = DATA_W_DEF,
    parameter int unsigned ADDRESS_BUS_WIDTH = ADDR_W_DEF,
    parameter int unsigned ACCESS_CYCLES     = ACC_CYC_DEF,
    parameter int unsigned STARVE_LIMIT      = STARVE_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    dram_arbiter_if.slave bus
);

    localparam int unsigned DW = DATA_BUS_WIDTH;
    localparam int unsigned AW = ADDRESS_BUS_WIDTH;
    localparam int unsigned TW = cnt_w(ACCESS_CYCLES);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          mem_rnw_q, mem_rnw_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] aux_rdata_q, aux_rdata_d;
    logic          force_aux, cpu_win, aux_win;
    logic          tmr_load, tmr_dec, tmr_last;

    // CPU has priority unless the starvation guard forces an aux turn.
    assign cpu_win = bus.cpu_req & ~(force_aux & bus.aux_req);
    assign aux_win = bus.aux_req & (~bus.cpu_req | force_aux);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned SW = cnt_w(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;
    logic          aux_grant, aux_active;

    assign aux_grant  = (state_q == ST_IDLE) & aux_win;
    assign aux_active = (state_q != ST_IDLE) & (owner_q == PORT_AUX);
    assign force_aux  = (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (aux_grant) begin
            starve_d = '0;
        end else if (bus.aux_req && !aux_active && !force_aux) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // The limit only matters when the guard is built in.
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_aux = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_rnw_d   = mem_rnw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_win || aux_win) begin
                    state_d     = ST_BUSY;
                    owner_d     = aux_win ? PORT_AUX : PORT_CPU;
                    mem_rnw_d   = aux_win ? bus.aux_rnw : bus.cpu_rnw;
                    mem_addr_d  = aux_win ? bus.aux_addr : bus.cpu_addr;
                    mem_wdata_d = aux_win ? bus.aux_wdata : bus.cpu_wdata;
                    tmr_load    = 1'b1;
                end
            end
            ST_BUSY: begin
                tmr_dec = 1'b1;
                if (tmr_last) begin
                    state_d = ST_ACK;
                    if (mem_rnw_q && owner_q == PORT_AUX) begin
                        aux_rdata_d = bus.mem_rdata;
                    end
                    if (mem_rnw_q && owner_q == PORT_CPU) begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                end
            end
            ST_ACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= PORT_CPU;
            mem_rnw_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    dram_arbiter_access_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(TW'(ACCESS_CYCLES)),
        .dec_i     (tmr_dec),
        .last_o    (tmr_last)
    );

    assign bus.mem_cs    = (state_q == ST_BUSY);
    assign bus.mem_rnw   = mem_rnw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = (state_q == ST_ACK) & (owner_q == PORT_CPU);
    assign bus.aux_ack   = (state_q == ST_ACK) & (owner_q == PORT_AUX);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.aux_rdata = aux_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: randomized scenario tests of dram_arbiter against a
// transaction-level timing/data model. Honors ARB_STARVE_GUARD_EN.
module tb_dram_arbiter;

    localparam int DW  = 24;
    localparam int AW  = 11;
    localparam int AC  = 2;
    localparam int SL  = 8;
    localparam int PER = AC + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;
    logic [DW-1:0] exp_rd [0:1];

    dram_arbiter_if #(.DATA_BUS_WIDTH(DW), .ADDRESS_BUS_WIDTH(AW)) bus ();

    dram_arbiter #(
        .DATA_BUS_WIDTH   (DW),
        .ADDRESS_BUS_WIDTH(AW),
        .ACCESS_CYCLES    (AC),
        .STARVE_LIMIT     (SL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.aux_req   = 1'b0;
        bus.cpu_rnw   = 1'b1;
        bus.aux_rnw   = 1'b1;
        bus.cpu_addr  = '0;
        bus.aux_addr  = '0;
        bus.cpu_wdata = '0;
        bus.aux_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_tot++;
        if ({bus.mem_cs, bus.mem_rnw, bus.cpu_ack, bus.aux_ack,
             bus.owner, bus.busy, bus.cpu_stall} !== 7'b0100000)
            $display("FAIL reset_ctrl got %b want 0100000",
                     {bus.mem_cs, bus.mem_rnw, bus.cpu_ack, bus.aux_ack,
                      bus.owner, bus.busy, bus.cpu_stall});
        else n_pass++;
        n_tot++;
        if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.aux_rdata} !== '0)
            $display("FAIL reset_data addr=%h wd=%h crd=%h ard=%h want 0",
                     bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.aux_rdata);
        else n_pass++;
        rst_n = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        next_cycle();
    endtask

    // One access on an otherwise quiet bus; arbiter must be IDLE on entry.
    task automatic test_single_access(input logic port, input logic rnw,
                                      input logic [AW-1:0] addr,
                                      input logic [DW-1:0] wd,
                                      input logic [DW-1:0] md,
                                      input string name);
        logic [4:0] obs, expv;
        logic ack, cs;
        bus.cpu_req   = ~port;
        bus.aux_req   = port;
        bus.cpu_rnw   = port ? 1'($urandom) : rnw;
        bus.aux_rnw   = port ? rnw : 1'($urandom);
        bus.cpu_addr  = port ? AW'($urandom) : addr;
        bus.aux_addr  = port ? addr : AW'($urandom);
        bus.cpu_wdata = port ? DW'($urandom) : wd;
        bus.aux_wdata = port ? wd : DW'($urandom);
        for (int c = 0; c <= AC + 1; c++) begin
            bus.mem_rdata = (c == AC) ? md : DW'($urandom);
            #1;
            cs   = (c >= 1) && (c <= AC);
            ack  = (c == AC + 1);
            expv = {cs, c >= 1, ack & ~port, ack & port, ~port & ~ack};
            obs  = {bus.mem_cs, bus.busy, bus.cpu_ack, bus.aux_ack,
                    bus.cpu_stall};
            n_tot++;
            if (obs !== expv)
                $display("FAIL %s cyc%0d cs/busy/cack/aack/stall got %b want %b",
                         name, c, obs, expv);
            else n_pass++;
            if (cs) begin
                n_tot++;
                if ({bus.mem_rnw, bus.mem_addr, bus.mem_wdata} !== {rnw, addr, wd})
                    $display("FAIL %s_bus cyc%0d rnw/addr/wd got %b/%h/%h want %b/%h/%h",
                             name, c, bus.mem_rnw, bus.mem_addr, bus.mem_wdata,
                             rnw, addr, wd);
                else n_pass++;
            end
            if (ack) begin
                if (rnw) exp_rd[port] = md;
                n_tot++;
                if ({bus.owner, bus.cpu_rdata, bus.aux_rdata} !==
                    {port, exp_rd[0], exp_rd[1]})
                    $display("FAIL %s_rdata owner/crd/ard got %b/%h/%h want %b/%h/%h",
                             name, bus.owner, bus.cpu_rdata, bus.aux_rdata,
                             port, exp_rd[0], exp_rd[1]);
                else n_pass++;
            end
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        bus.aux_req = 1'b0;
        #1;
        n_tot++;
        if ({bus.busy, bus.mem_cs} !== 2'b00)
            $display("FAIL %s_idle busy/cs got %b want 00", name,
                     {bus.busy, bus.mem_cs});
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_cpu_read();
        test_single_access(1'b0, 1'b1, 11'd5, DW'($urandom), 24'hABCDEF,
                           "cpu_read");
    endtask

    task automatic test_aux_write();
        test_single_access(1'b1, 1'b0, 11'd1023, 24'h000123, DW'($urandom),
                           "aux_write");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            test_single_access(1'($urandom), 1'($urandom), AW'($urandom),
                               DW'($urandom), DW'($urandom), "rand");
            repeat ($urandom_range(0, 2)) next_cycle();
        end
    endtask

    task automatic test_simultaneous();
        int cpu_at, aux_at, both;
        logic drop_c, drop_a;
        cpu_at = -1;
        aux_at = -1;
        both   = 0;
        drop_c = 1'b0;
        drop_a = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.aux_req   = 1'b1;
        bus.cpu_rnw   = 1'b0;
        bus.aux_rnw   = 1'b0;
        bus.cpu_addr  = AW'($urandom);
        bus.aux_addr  = AW'($urandom);
        bus.cpu_wdata = DW'($urandom);
        bus.aux_wdata = DW'($urandom);
        for (int c = 0; c < 3 * PER; c++) begin
            if (drop_c) bus.cpu_req = 1'b0;
            if (drop_a) bus.aux_req = 1'b0;
            bus.mem_rdata = DW'($urandom);
            #1;
            if (bus.cpu_ack && bus.aux_ack) both++;
            if (bus.cpu_ack && cpu_at < 0) begin
                cpu_at = c;
                drop_c = 1'b1;
            end
            if (bus.aux_ack && aux_at < 0) begin
                aux_at = c;
                drop_a = 1'b1;
            end
            next_cycle();
        end
        n_tot++;
        if (cpu_at !== AC + 1)
            $display("FAIL simul_cpu_ack cycle got %0d want %0d", cpu_at, AC + 1);
        else n_pass++;
        n_tot++;
        if (aux_at !== AC + 1 + PER)
            $display("FAIL simul_aux_ack cycle got %0d want %0d", aux_at,
                     AC + 1 + PER);
        else n_pass++;
        n_tot++;
        if (both !== 0)
            $display("FAIL simul_both_ack count got %0d want 0", both);
        else n_pass++;
        n_tot++;
        if ({bus.cpu_rdata, bus.aux_rdata} !== {exp_rd[0], exp_rd[1]})
            $display("FAIL simul_rdata got %h/%h want %h/%h", bus.cpu_rdata,
                     bus.aux_rdata, exp_rd[0], exp_rd[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] cap;
        logic [3:0] obs, expv;
        int ph;
        a   = '0;
        cap = '0;
        bus.aux_req = 1'b0;
        bus.cpu_req = 1'b1;
        bus.cpu_rnw = 1'b1;
        for (int c = 0; c < 3 * PER; c++) begin
            ph = c % PER;
            if (ph == 0) begin
                a = AW'($urandom);
                bus.cpu_addr  = a;
                bus.cpu_wdata = DW'($urandom);
            end
            bus.mem_rdata = DW'($urandom);
            if (ph == AC) cap = bus.mem_rdata;
            #1;
            expv = {(ph >= 1) && (ph <= AC), ph == AC + 1, 1'b0, ph != AC + 1};
            obs  = {bus.mem_cs, bus.cpu_ack, bus.aux_ack, bus.cpu_stall};
            n_tot++;
            if (obs !== expv)
                $display("FAIL b2b cyc%0d cs/cack/aack/stall got %b want %b",
                         c, obs, expv);
            else n_pass++;
            if (ph >= 1 && ph <= AC) begin
                n_tot++;
                if (bus.mem_addr !== a)
                    $display("FAIL b2b_addr cyc%0d got %h want %h", c,
                             bus.mem_addr, a);
                else n_pass++;
            end
            if (ph == AC + 1) begin
                exp_rd[0] = cap;
                n_tot++;
                if (bus.cpu_rdata !== exp_rd[0])
                    $display("FAIL b2b_rdata cyc%0d got %h want %h", c,
                             bus.cpu_rdata, exp_rd[0]);
                else n_pass++;
            end
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        #1;
        n_tot++;
        if (bus.busy !== 1'b0)
            $display("FAIL b2b_idle busy got %b want 0", bus.busy);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_busy();
        bus.aux_req  = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_rnw  = 1'b1;
        bus.cpu_addr = AW'($urandom);
        next_cycle();
        next_cycle();
        #1;
        n_tot++;
        if (bus.mem_cs !== 1'b1)
            $display("FAIL rstbusy_pre cs got %b want 1", bus.mem_cs);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_tot++;
        if ({bus.mem_cs, bus.busy, bus.cpu_ack, bus.aux_ack} !== 4'b0000)
            $display("FAIL rstbusy_now cs/busy/cack/aack got %b want 0000",
                     {bus.mem_cs, bus.busy, bus.cpu_ack, bus.aux_ack});
        else n_pass++;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        next_cycle();
        rst_n = 1'b1;
        bus.cpu_req = 1'b0;
        for (int c = 0; c < 2 * PER; c++) begin
            #1;
            n_tot++;
            if ({bus.mem_cs, bus.busy, bus.cpu_ack, bus.aux_ack} !== 4'b0000)
                $display("FAIL rstbusy_after cyc%0d got %b want 0000", c,
                         {bus.mem_cs, bus.busy, bus.cpu_ack, bus.aux_ack});
            else n_pass++;
            next_cycle();
        end
        n_tot++;
        if (bus.cpu_rdata !== exp_rd[0])
            $display("FAIL rstbusy_rdata got %h want %h", bus.cpu_rdata,
                     exp_rd[0]);
        else n_pass++;
    endtask

    task automatic test_starve();
        int s, aux_acks, t0, ph;
        logic drop_a, aux_turn;
        logic [2:0] obs, expv;
        aux_acks = 0;
        drop_a   = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
`ifdef ARB_STARVE_GUARD_EN
        // Aux has waited every cycle since 0, so it wins the first free slot
        // at or after STARVE_LIMIT cycles of waiting.
        s = ((SL + PER - 1) / PER) * PER;
`else
        s = -1;
`endif
        bus.cpu_req   = 1'b1;
        bus.aux_req   = 1'b1;
        bus.cpu_rnw   = 1'b0;
        bus.aux_rnw   = 1'b0;
        bus.cpu_addr  = AW'($urandom);
        bus.aux_addr  = AW'($urandom);
        bus.cpu_wdata = DW'($urandom);
        bus.aux_wdata = DW'($urandom);
        for (int c = 0; c < 6 * PER; c++) begin
            if (drop_a) bus.aux_req = 1'b0;
            bus.mem_rdata = DW'($urandom);
            #1;
            ph       = c % PER;
            t0       = c - ph;
            aux_turn = (t0 == s);
            expv = {(ph >= 1) && (ph <= AC), (ph == AC + 1) && !aux_turn,
                    (ph == AC + 1) && aux_turn};
            obs  = {bus.mem_cs, bus.cpu_ack, bus.aux_ack};
            n_tot++;
            if (obs !== expv)
                $display("FAIL starve cyc%0d cs/cack/aack got %b want %b",
                         c, obs, expv);
            else n_pass++;
            if (bus.aux_ack) begin
                aux_acks++;
                drop_a = 1'b1;
            end
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        bus.aux_req = 1'b0;
        n_tot++;
        if (aux_acks !== ((s >= 0) ? 1 : 0))
            $display("FAIL starve_aux_grants got %0d want %0d", aux_acks,
                     (s >= 0) ? 1 : 0);
        else n_pass++;
        n_tot++;
        if ({bus.cpu_rdata, bus.aux_rdata} !== {exp_rd[0], exp_rd[1]})
            $display("FAIL starve_rdata got %h/%h want %h/%h", bus.cpu_rdata,
                     bus.aux_rdata, exp_rd[0], exp_rd[1]);
        else n_pass++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_aux_write();
        test_random();
        test_simultaneous();
        test_back_to_back();
        test_reset_busy();
        test_starve();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 24, data word width.
REQ-002 SHALL have parameter ADDRESS_BUS_WIDTH, default 11, DRAM address width.
REQ-003 SHALL have parameter ACCESS_CYCLES, default 2, cycles mem_cs is held per access (>=1).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, aux wait cycles before forced aux grant (>=1).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low.
REQ-008 cpu_req / cpu_rnw  in  1 / 1  CPU access request; 1 = read, 0 = write.
REQ-009 cpu_addr / cpu_wdata  in  ADDRESS_BUS_WIDTH / DATA_BUS_WIDTH  CPU address, store data.
REQ-010 cpu_ack / cpu_rdata  out  1 / DATA_BUS_WIDTH  one-cycle completion pulse; read data.
REQ-011 cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), gates PC/IR write enables.
REQ-012 aux_req, aux_rnw, aux_addr, aux_wdata, aux_ack, aux_rdata  same directions/widths as CPU set  loader/debug port.
REQ-013 mem_cs / mem_rnw  out  1 / 1  DRAM chip select; read_not_write.
REQ-014 mem_addr / mem_wdata  out  ADDRESS_BUS_WIDTH / DATA_BUS_WIDTH  DRAM address, write data.
REQ-015 mem_rdata  in  DATA_BUS_WIDTH  DRAM read data.
REQ-016 owner  out  1  port of current/last grant (0 = CPU, 1 = aux); busy  out  1  state != IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> ACK -> IDLE; no other states reachable.
REQ-018 IDLE: sample requests at clock edge; if any granted, latch rnw/addr/wdata of winner into mem_* registers, set owner, load timer with ACCESS_CYCLES, go BUSY.
REQ-019 Arbitration: CPU wins on simultaneous requests, except per REQ-031.
REQ-020 BUSY: mem_cs=1, mem_* stable; timer decrements each cycle; on timer==1 capture mem_rdata into owner's rdata register (reads only), go ACK.
REQ-021 ACK: mem_cs=0; owner's ack=1 for exactly this cycle; requests ignored; next state IDLE.
REQ-022 Latency: req first high in cycle 0 with arbiter IDLE -> mem_cs high cycles 1..ACCESS_CYCLES -> ack in cycle ACCESS_CYCLES+1.
REQ-023 Requester SHALL hold req and payload until ack; req still high after ACK is a new request.
REQ-024 Throughput: at most one access per ACCESS_CYCLES+2 cycles.
REQ-025 Writes: mem_rnw=0, rdata registers unchanged.
REQ-026 rdata registers hold value until the next read completing on that port.
REQ-027 req dropped mid-BUSY: access completes, ack still pulses.
REQ-028 Non-owner ack SHALL never assert; cpu_ack and aux_ack never high together.

Reset
REQ-029 reset low: immediately state=IDLE, mem_cs=0, mem_rnw=1, mem_addr=0, mem_wdata=0, acks=0, rdata=0, owner=0, timer=0, starve counter=0.
REQ-030 Reset during BUSY: access aborted, no ack issued after release.

Configuration
REQ-031 With ARB_STARVE_GUARD_EN defined: counter increments (saturating at STARVE_LIMIT) each cycle aux_req=1 and aux not owner-in-progress; clears on aux grant; in IDLE with both requesting and counter==STARVE_LIMIT, aux wins.
REQ-032 Without ARB_STARVE_GUARD_EN: no counter logic; strict CPU priority.

Structure
REQ-033 Width defaults and FSM state encodings (IDLE=0, BUSY=1, ACK=2) SHALL live in shared params.v.
REQ-034 Access timer SHALL be sub-module access_timer (load, decrement, last flag).

Verification
REQ-035 CPU read addr 11'd5, mem_rdata=24'hABCDEF, ACCESS_CYCLES=2 -> mem_cs cycles 1-2, cpu_ack cycle 3, cpu_rdata=24'hABCDEF.
REQ-036 CPU and aux req same cycle -> CPU served first, aux_ack exactly ACCESS_CYCLES+2 cycles after cpu_ack.
REQ-037 With ARB_STARVE_GUARD_EN, STARVE_LIMIT=8, CPU req continuous, aux req held -> aux granted once counter reaches 8; without macro aux never granted.
REQ-038 Aux write addr 11'd1023, wdata 24'h000123 -> mem_rnw=0, mem_addr=1023, mem_wdata=24'h000123 while mem_cs; aux_rdata unchanged.
REQ-039 reset low in second BUSY cycle -> mem_cs=0 same cycle, no ack after release, state IDLE.
REQ-040 cpu_req held high across ack -> cpu_stall low only in ack cycle, second access starts next IDLE.
